// File: rtl/bram16_bus_bridge_if.sv
// bram16_bus_bridge_if
//
// Request/response bundle between an on-chip bus master and bram16_bus_bridge.
//
// Signals:
//   req_valid  request present (master -> bridge)
//   req_ready  bridge can accept; high only while idle (bridge -> master)
//   req_we     1 = write, 0 = read
//   req_addr   byte address, bits [1:0] ignored
//   req_wdata  32-bit write data, [15:0] is the low halfword
//   req_wstrb  byte strobes, only meaningful for writes
//   rsp_valid  one-cycle completion pulse, no backpressure
//   rsp_rdata  read word, 0 for writes
//
// Modports:
//   master  the requester side
//   slave   the bridge side

interface bram16_bus_bridge_if #(
    parameter int unsigned ADDR_W = 13
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_wstrb,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_wstrb,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

endinterface

// File: rtl/bram16_bus_bridge.sv
// bram16_bus_bridge
//
// Converts one 32-bit word access from the on-chip bus into two sequential
// 16-bit accesses on port A of a 4096x16 block RAM with unregistered
// (one-cycle latency) read data. Port B of the RAM is left to another master.
//
// Sequence per access: IDLE -> LO -> HI -> TAIL -> RESP -> IDLE.
//   LO   drives the low halfword address, RAM data for it arrives in HI.
//   HI   drives the high halfword address, RAM data for it arrives in TAIL.
//   TAIL RAM idle, captures the high halfword.
//   RESP one-cycle rsp_valid pulse.
//
// Ports:
//   clk        single clock, also the RAM's clka
//   rst        synchronous active-high reset
//   bus        request/response bundle (slave modport)
//   bram_addr  halfword address to the RAM (addra)
//   bram_ce    RAM chip select (cea)
//   bram_we    RAM byte write enables (wea)
//   bram_di    RAM write data (dia)
//   bram_do    RAM read data (doa), valid the cycle after the address edge
//
// Optional feature (macro BRAM16_BRIDGE_WSKIP_EN):
//   When defined, writes skip RAM cycles whose byte strobes are all zero and
//   never visit TAIL, since there is no read data to wait for. Reads are
//   unaffected. When undefined every access takes the full 4-cycle sequence.

module bram16_bus_bridge #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    bram16_bus_bridge_if.slave      bus,
    output logic [ADDR_W-2:0]       bram_addr,
    output logic                    bram_ce,
    output logic [1:0]              bram_we,
    output logic [15:0]             bram_di,
    input  logic [15:0]             bram_do
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
        StTail,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Latched request fields
    logic             we_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    // Captured read halves
    logic [15:0]      lo_q;
    logic [15:0]      hi_q;

    logic             accept;

    // Word alignment: the byte-offset bits carry no information
    logic             unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    always_comb begin
        accept = (state_q == StIdle) && bus.req_valid;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef BRAM16_BRIDGE_WSKIP_EN
                    // Decided from the incoming request: fields are not latched yet
                    if (bus.req_we && (bus.req_wstrb == 4'b0000)) begin
                        state_d = StResp;
                    end else if (bus.req_we && (bus.req_wstrb[1:0] == 2'b00)) begin
                        state_d = StHi;
                    end else begin
                        state_d = StLo;
                    end
`else
                    state_d = StLo;
`endif
                end
            end
            StLo: begin
`ifdef BRAM16_BRIDGE_WSKIP_EN
                if (we_q && (wstrb_q[3:2] == 2'b00)) begin
                    state_d = StResp;
                end else begin
                    state_d = StHi;
                end
`else
                state_d = StHi;
`endif
            end
            StHi: begin
`ifdef BRAM16_BRIDGE_WSKIP_EN
                // Writes have no high halfword to collect
                state_d = we_q ? StResp : StTail;
`else
                state_d = StTail;
`endif
            end
            StTail:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                idx_q   <= bus.req_addr[ADDR_W-1:2];
                wdata_q <= bus.req_wdata;
                // Reads must never write the RAM, whatever the strobes say
                wstrb_q <= bus.req_we ? bus.req_wstrb : 4'b0000;
            end
            // doa reflects the address presented in the previous cycle
            if (state_q == StHi) begin
                lo_q <= bram_do;
            end
            if (state_q == StTail) begin
                hi_q <= bram_do;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bram_ce       = 1'b0;
        bram_addr     = '0;
        bram_we       = 2'b00;
        bram_di       = '0;
        case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
            end
            StLo: begin
                bram_ce   = 1'b1;
                bram_addr = {idx_q, 1'b0};
                bram_we   = wstrb_q[1:0];
                bram_di   = wdata_q[15:0];
            end
            StHi: begin
                bram_ce   = 1'b1;
                bram_addr = {idx_q, 1'b1};
                bram_we   = wstrb_q[3:2];
                bram_di   = wdata_q[31:16];
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = we_q ? 32'h0 : {hi_q, lo_q};
            end
            default: begin
            end
        endcase
    end

endmodule
